core_mem_unit: RTL and testbench

- Parametrised memory access unit between the multicycle core's control FSM and a single-beat valid/ready system bus.
- Handles both instruction fetch and load/store data accesses.
- Generalises the core's direct PC-to-address wiring:
  - XLEN-wide data path
  - byte/half/word/double sizes with lane steering and sign extension
  - alignment checking
  - a bus timeout
- Exactly one outstanding transaction at a time.

---
 rtl/core_mem_pkg.sv | 57 +++++
 rtl/core_mem_unit_align.sv | 74 +++++++
 rtl/core_mem_unit.sv | 164 ++++++++++++++++
 tb/tb_core_mem_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// core_mem_pkg
// Shared types for the core memory access unit: request kinds, access sizes,
// response error codes and the unit's FSM states, plus small helpers that
// turn an access size into its byte mask and its alignment mask.
package core_mem_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } req_kind_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_ILLEGAL    = 2'd3
    } mem_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Byte-enable pattern of an access before it is shifted into its lane.
    function automatic logic [7:0] size_mask(input mem_size_e sz);
        logic [7:0] m;
        case (sz)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input mem_size_e sz);
        logic [2:0] m;
        case (sz)
            SIZE_B:  m = 3'b000;
            SIZE_H:  m = 3'b001;
            SIZE_W:  m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/core_mem_unit_align.sv
// mem_lane_align
// Purely combinational lane logic for core_mem_unit.
// Request side: bus-aligned address, lane offset, steered store data, byte
//   enables and the legality/alignment verdict for the incoming request.
// Load side: extracts the addressed bytes from a full bus word using the
//   captured offset/size and zero- or sign-extends them to XLEN.
// Ports:
//   req_kind/req_addr/req_size/req_wdata  incoming request fields
//   st_addr/st_off/st_wdata/st_be         steered bus fields for the request
//   chk_err                               OK / MISALIGNED / ILLEGAL
//   ld_off/ld_size/ld_unsigned/ld_rdata   captured load shape + bus read data
//   ld_data                               extended load result
module mem_lane_align
    import core_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic [1:0]                  req_kind,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [1:0]                  req_size,
    input  logic [XLEN-1:0]             req_wdata,
    output logic [ADDR_W-1:0]           st_addr,
    output logic [$clog2(XLEN/8)-1:0]   st_off,
    output logic [XLEN-1:0]             st_wdata,
    output logic [XLEN/8-1:0]           st_be,
    output logic [1:0]                  chk_err,
    input  logic [$clog2(XLEN/8)-1:0]   ld_off,
    input  logic [1:0]                  ld_size,
    input  logic                        ld_unsigned,
    input  logic [XLEN-1:0]             ld_rdata,
    output logic [XLEN-1:0]             ld_data
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    mem_size_e       sz;
    logic [XLEN-1:0] shifted;

    assign sz       = mem_size_e'(req_size);
    assign st_off   = req_addr[OFF_W-1:0];
    assign st_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign st_wdata = req_wdata << {st_off, 3'b000};
    assign st_be    = BE_W'(size_mask(sz)) << st_off;

    always_comb begin
        chk_err = ERR_OK;
        if (XLEN == 32 && sz == SIZE_D) begin
            chk_err = ERR_ILLEGAL;
        end else if (req_kind == FETCH && sz != SIZE_W) begin
            chk_err = ERR_ILLEGAL;
        end else if (req_kind == 2'd3) begin
            // Undefined kind encoding is rejected rather than guessed at.
            chk_err = ERR_ILLEGAL;
        end else if ((req_addr[2:0] & align_mask(sz)) != 3'b000) begin
            chk_err = ERR_MISALIGNED;
        end
    end

    assign shifted = ld_rdata >> {ld_off, 3'b000};

    // Size casts of a $signed operand sign-extend; of a plain slice, zero-extend.
    always_comb begin
        ld_data = shifted;
        case (mem_size_e'(ld_size))
            SIZE_B:  ld_data = ld_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            SIZE_H:  ld_data = ld_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            SIZE_W:  ld_data = ld_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/core_mem_unit.sv
// core_mem_unit
// Memory access unit between the multicycle core's control FSM and a
// single-beat valid/ready bus. Accepts one FETCH/LOAD/STORE at a time,
// rejects illegal or misaligned requests without touching the bus, steers
// store data into byte lanes, extracts and extends load data, and aborts a
// bus request that is not accepted within TIMEOUT cycles (0 = never).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ce                      core clock enable, gates request acceptance only
//   req_valid/req_ready     core request handshake
//   req_kind/addr/size/unsigned/wdata  request fields
//   rsp_valid/rsp_data/rsp_err        one-cycle response pulse + held result
//   bus_valid/bus_ready     bus handshake (bus_rdata valid with bus_ready)
//   bus_we/addr/wdata/be    registered bus request fields
module core_mem_unit
    import core_mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_kind,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_data,
    output logic [1:0]          rsp_err,
    output logic                bus_valid,
    input  logic                bus_ready,
    input  logic [XLEN-1:0]     bus_rdata,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_be
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

    mem_state_e        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [OFF_W-1:0]  ld_off_q;
    logic [1:0]        ld_size_q;
    logic              ld_unsigned_q;
    logic              is_store_q;

    logic [ADDR_W-1:0] st_addr;
    logic [OFF_W-1:0]  st_off;
    logic [XLEN-1:0]   st_wdata;
    logic [BE_W-1:0]   st_be;
    logic [1:0]        chk_err;
    logic [XLEN-1:0]   ld_data;
    logic              handshake;
    logic              is_store;
    logic              is_fetch;

    assign req_ready = (state == ST_IDLE) & ce & ~reset;
    assign handshake = req_valid & req_ready;
    assign is_store  = (req_kind == STORE);
    assign is_fetch  = (req_kind == FETCH);

    mem_lane_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_align (
        .req_kind    (req_kind),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .st_addr     (st_addr),
        .st_off      (st_off),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .chk_err     (chk_err),
        .ld_off      (ld_off_q),
        .ld_size     (ld_size_q),
        .ld_unsigned (ld_unsigned_q),
        .ld_rdata    (bus_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            bus_valid     <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_be        <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= ERR_OK;
            ld_off_q      <= '0;
            ld_size_q     <= SIZE_B;
            ld_unsigned_q <= 1'b0;
            is_store_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        if (chk_err != ERR_OK) begin
                            // Rejected requests answer directly without a bus cycle.
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= chk_err;
                            rsp_data  <= '0;
                        end else begin
                            state         <= ST_REQ;
                            wait_cnt      <= '0;
                            bus_valid     <= 1'b1;
                            bus_we        <= is_store;
                            bus_addr      <= st_addr;
                            bus_wdata     <= is_store ? st_wdata : '0;
                            bus_be        <= st_be;
                            ld_off_q      <= st_off;
                            // A fetch is an unsigned word load.
                            ld_size_q     <= is_fetch ? SIZE_W : req_size;
                            ld_unsigned_q <= req_unsigned | is_fetch;
                            is_store_q    <= is_store;
                        end
                    end
                end
                ST_REQ: begin
                    // bus_ready is checked first so a late accept beats the timeout.
                    if (bus_ready) begin
                        state     <= ST_RESP;
                        bus_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_OK;
                        rsp_data  <= is_store_q ? '0 : ld_data;
                    end else if (TIMEOUT > 0 && wait_cnt == CNT_LAST) begin
                        state     <= ST_RESP;
                        bus_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_data  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_valid <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_unit.sv
// tb_core_mem_unit
// Bench for core_mem_unit. Drives an XLEN=32/TIMEOUT=4 instance and an
// XLEN=64/TIMEOUT=16 instance, one transaction at a time, and compares bus
// fields, latency and responses against an arithmetic reference model.
module tb_core_mem_unit;

    localparam int TO32 = 4;
    localparam int TO64 = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        req_valid32, req_valid64;
    logic [1:0]  req_kind;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        bus_ready32, bus_ready64;
    logic [63:0] bus_rdata;

    logic        a_req_ready, a_rsp_valid, a_bus_valid, a_bus_we;
    logic [31:0] a_rsp_data, a_bus_addr, a_bus_wdata;
    logic [1:0]  a_rsp_err;
    logic [3:0]  a_bus_be;

    logic        b_req_ready, b_rsp_valid, b_bus_valid, b_bus_we;
    logic [63:0] b_rsp_data, b_bus_wdata;
    logic [31:0] b_bus_addr;
    logic [1:0]  b_rsp_err;
    logic [7:0]  b_bus_be;

    logic        sel64;
    logic        o_req_ready, o_rsp_valid, o_bus_valid, o_bus_we;
    logic [63:0] o_rsp_data, o_bus_wdata;
    logic [31:0] o_bus_addr;
    logic [1:0]  o_rsp_err;
    logic [7:0]  o_bus_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_mem_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO32)) dut32 (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(req_valid32), .req_ready(a_req_ready),
        .req_kind(req_kind), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .bus_valid(a_bus_valid), .bus_ready(bus_ready32), .bus_rdata(bus_rdata[31:0]),
        .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_be(a_bus_be)
    );

    core_mem_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO64)) dut64 (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(req_valid64), .req_ready(b_req_ready),
        .req_kind(req_kind), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .bus_valid(b_bus_valid), .bus_ready(bus_ready64), .bus_rdata(bus_rdata),
        .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_be(b_bus_be)
    );

    always_comb begin
        if (sel64) begin
            o_req_ready = b_req_ready;  o_rsp_valid = b_rsp_valid;
            o_rsp_data  = b_rsp_data;   o_rsp_err   = b_rsp_err;
            o_bus_valid = b_bus_valid;  o_bus_we    = b_bus_we;
            o_bus_addr  = b_bus_addr;   o_bus_wdata = b_bus_wdata;
            o_bus_be    = b_bus_be;
        end else begin
            o_req_ready = a_req_ready;  o_rsp_valid = a_rsp_valid;
            o_rsp_data  = {32'b0, a_rsp_data};  o_rsp_err = a_rsp_err;
            o_bus_valid = a_bus_valid;  o_bus_we    = a_bus_we;
            o_bus_addr  = a_bus_addr;   o_bus_wdata = {32'b0, a_bus_wdata};
            o_bus_be    = {4'b0, a_bus_be};
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: byte arithmetic straight from the access rules.
    function automatic void model(input bit x64, input logic [1:0] kind, input logic [31:0] addr,
                                  input logic [1:0] size, input bit uns,
                                  input logic [63:0] wdata, input logic [63:0] rdata,
                                  output logic [1:0] err, output logic [31:0] baddr,
                                  output logic [7:0] be, output bit we,
                                  output logic [63:0] bwd, output logic [63:0] rd);
        int xb, nb, off;
        logic [127:0] v, m;
        xb = x64 ? 8 : 4;
        nb = 1 << size;
        off = int'(addr % xb);
        if (!x64 && size == 2'd3)                err = 2'd3;
        else if (kind == 2'd0 && size != 2'd2)   err = 2'd3;
        else if (addr % nb != 0)                 err = 2'd1;
        else                                     err = 2'd0;
        baddr = addr - off;
        be = 8'(((1 << nb) - 1) << off);
        we = (kind == 2'd2);
        v = {64'b0, wdata} << (8 * off);
        if (!x64) v[127:32] = '0;
        bwd = we ? v[63:0] : 64'b0;
        v = {64'b0, rdata};
        if (!x64) v[127:32] = '0;
        v = v >> (8 * off);
        m = (128'd1 << (8 * nb)) - 128'd1;
        v = v & m;
        if (kind == 2'd1 && !uns && v[8*nb-1]) v = v | ~m;
        if (!x64) v[127:32] = '0;
        rd = we ? 64'b0 : v[63:0];
    endfunction

    // delay: bus_valid cycles before bus_ready is raised (0 = first cycle), -1 = never.
    task automatic txn(input bit x64, input logic [1:0] kind, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int delay);
        logic [1:0]  e_err, exp_err;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        bit          e_we;
        logic [63:0] e_wd, e_rd;
        int to, exp_cycles, bus_cycles, lat;
        bit got_rsp;
        model(x64, kind, addr, size, uns, wdata, rdata, e_err, e_addr, e_be, e_we, e_wd, e_rd);
        to = x64 ? TO64 : TO32;
        if (e_err != 2'd0) begin
            exp_cycles = 0; exp_err = e_err;
        end else if (delay >= 0 && delay < to) begin
            exp_cycles = delay + 1; exp_err = 2'd0;
        end else begin
            exp_cycles = to; exp_err = 2'd2;
        end
        @(negedge clk);
        sel64 = x64; ce = 1'b1;
        req_kind = kind; req_addr = addr; req_size = size; req_unsigned = uns;
        req_wdata = wdata; bus_rdata = rdata;
        if (x64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        #1 check_val("req_ready", o_req_ready, 1);
        @(posedge clk);
        bus_cycles = 0; got_rsp = 0; lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            req_valid32 = 1'b0; req_valid64 = 1'b0;
            if (o_rsp_valid) begin
                got_rsp = 1; lat = n;
                break;
            end
            if (o_bus_valid) begin
                bus_cycles++;
                if (bus_cycles == 1 || bus_cycles == exp_cycles) begin
                    check_val("bus_addr", o_bus_addr, e_addr);
                    check_val("bus_be", o_bus_be, e_be);
                    check_val("bus_we", o_bus_we, e_we);
                    check_val("bus_wdata", o_bus_wdata, e_wd);
                end
                bus_ready32 = !x64 && (bus_cycles - 1 == delay);
                bus_ready64 =  x64 && (bus_cycles - 1 == delay);
            end else begin
                bus_ready32 = 1'b0; bus_ready64 = 1'b0;
            end
        end
        bus_ready32 = 1'b0; bus_ready64 = 1'b0;
        check_val("rsp_seen", got_rsp, 1);
        check_val("bus_cycles", bus_cycles, exp_cycles);
        check_val("latency", lat, exp_cycles + 1);
        check_val("rsp_err", o_rsp_err, exp_err);
        check_val("bus_valid_at_rsp", o_bus_valid, 0);
        if (exp_err == 2'd0) check_val("rsp_data", o_rsp_data, e_rd);
        @(negedge clk);
        check_val("rsp_pulse", o_rsp_valid, 0);
        check_val("rsp_err_hold", o_rsp_err, exp_err);
        if (exp_err == 2'd0) check_val("rsp_data_hold", o_rsp_data, e_rd);
    endtask

    initial begin
        logic [1:0]  k, s;
        logic [31:0] a;
        int d, to;
        bit x;
        reset = 1'b1; ce = 1'b0; sel64 = 1'b0;
        req_valid32 = 1'b0; req_valid64 = 1'b0; req_kind = 2'd0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
        bus_ready32 = 1'b0; bus_ready64 = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ce = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sel64 = (i == 1);
            #1;
            check_val("rst_req_ready", o_req_ready, 0);
            check_val("rst_bus_valid", o_bus_valid, 0);
            check_val("rst_rsp_valid", o_rsp_valid, 0);
            check_val("rst_rsp_data", o_rsp_data, 0);
            check_val("rst_rsp_err", o_rsp_err, 0);
            check_val("rst_bus_be", o_bus_be, 0);
        end
        reset = 1'b0;

        // Directed cases
        txn(0, 2'd1, 32'h103, 2'd0, 0, 64'h0, 64'h80AABBCC, 0);
        check_val("tp_load_b", o_rsp_data, 64'hFFFFFF80);
        txn(0, 2'd2, 32'h202, 2'd1, 0, 64'h1234, 64'h0, 1);
        check_val("tp_store_h", o_rsp_data, 64'h0);
        txn(0, 2'd1, 32'h101, 2'd2, 0, 64'h0, 64'h0, 0);
        check_val("tp_misaligned", o_rsp_err, 2'd1);
        txn(0, 2'd1, 32'h100, 2'd3, 0, 64'h0, 64'h0, 0);
        check_val("tp_illegal_d32", o_rsp_err, 2'd3);
        txn(0, 2'd0, 32'h100, 2'd0, 0, 64'h0, 64'h0, 0);
        check_val("tp_illegal_fetch", o_rsp_err, 2'd3);
        txn(0, 2'd1, 32'h300, 2'd2, 0, 64'h0, 64'h11223344, -1);
        check_val("tp_timeout", o_rsp_err, 2'd2);
        txn(0, 2'd1, 32'h300, 2'd2, 0, 64'h0, 64'h11223344, 3);
        check_val("tp_late_ready", o_rsp_data, 64'h11223344);
        txn(1, 2'd0, 32'h1004, 2'd2, 0, 64'h0, 64'hDEADBEEF_00000013, 0);
        check_val("tp_fetch64", o_rsp_data, 64'h00000000_DEADBEEF);
        txn(1, 2'd1, 32'h1000, 2'd3, 1, 64'h0, 64'hFEDCBA98_76543210, 2);
        check_val("tp_load_d64", o_rsp_data, 64'hFEDCBA98_76543210);
        txn(1, 2'd1, 32'h2006, 2'd1, 0, 64'h0, 64'h9ABC_0000_0000_0000, -1);

        // ce low blocks acceptance
        @(negedge clk);
        sel64 = 1'b0; ce = 1'b0; req_kind = 2'd1; req_addr = 32'h100; req_size = 2'd2;
        req_valid32 = 1'b1;
        #1 check_val("ce_req_ready", o_req_ready, 0);
        repeat (3) begin
            @(negedge clk);
            check_val("ce_bus_valid", o_bus_valid, 0);
            check_val("ce_rsp_valid", o_rsp_valid, 0);
        end
        req_valid32 = 1'b0; ce = 1'b1;

        // Reset while a bus request is pending
        @(negedge clk);
        sel64 = 1'b1; req_kind = 2'd1; req_addr = 32'h2000; req_size = 2'd2; req_valid64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid64 = 1'b0;
        check_val("rr_bus_valid1", o_bus_valid, 1);
        @(negedge clk);
        check_val("rr_bus_valid2", o_bus_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("rr_bus_drop", o_bus_valid, 0);
        check_val("rr_no_rsp", o_rsp_valid, 0);
        check_val("rr_ready_in_reset", o_req_ready, 0);
        reset = 1'b0;
        #1 check_val("rr_ready_back", o_req_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check_val("rr_quiet", o_rsp_valid, 0);
        end

        // Randomised traffic on both widths
        for (int i = 0; i < 300; i++) begin
            x = i[0];
            to = x ? TO64 : TO32;
            k = 2'($urandom_range(0, 2));
            s = 2'($urandom_range(0, 3));
            if (k == 2'd0 && $urandom_range(0, 3) != 0) s = 2'd2;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, to + 1));
            txn(x, k, a, s, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
